// File: rtl/muxpga_cfg_loader.sv
// muxpga_cfg_loader: serial configuration loader for a 4x4 MUXPGA fabric.
// It hunts for a 1010 header, shifts in CELLS bytes of cell configuration
// plus an XOR checksum, and commits the frame to cfg_bus only when the
// checksum matches.
//
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   cfg_en       - loading enable; low aborts a frame (except during EVAL)
//   cfg_valid    - qualifies cfg_data
//   cfg_data     - serial config bit
//   cfg_ready    - loader accepts a bit this cycle
//   cfg_bus      - active configuration, cell k at [8k+7:8k]
//   cfg_done     - one-cycle pulse on a committed frame
//   cfg_err      - sticky checksum-failure flag
//   fabric_hold  - holds the fabric in reset while config is invalid/in flux
`timescale 1ns/1ps
module muxpga_cfg_loader #(
  parameter int unsigned CELLS     = 16,
  parameter int unsigned CELL_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_en,
  input  logic                       cfg_valid,
  input  logic                       cfg_data,
  output logic                       cfg_ready,
  output logic [CELLS*CELL_BITS-1:0] cfg_bus,
  output logic                       cfg_done,
  output logic                       cfg_err,
  output logic                       fabric_hold
);

  localparam int unsigned PAY_BITS = CELLS * CELL_BITS;
  localparam int unsigned CNT_W    = $clog2(PAY_BITS + 8 + 1);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK, EVAL} state_t;

  state_t               state, state_next;
  logic [2:0]           hist;      // previous three bits; the current bit completes the 4-bit window
  logic [CNT_W-1:0]     bit_cnt;   // frame bit index, payload and checksum
  logic [6:0]           byte_sr;   // partial payload byte
  logic [7:0]           run_xor;
  logic [7:0]           rx_sum;
  logic [PAY_BITS-1:0]  shadow;
  logic                 loaded;

  logic                 accept;
  logic                 hdr_hit;
  logic                 byte_last;
  logic                 pay_last;
  logic                 chk_last;
  logic                 sum_ok;
  logic                 abort;
  logic                 loaded_next;
  logic [7:0]           byte_new;

  assign accept      = cfg_en & cfg_valid & cfg_ready;
  assign hdr_hit     = ({hist, cfg_data} == 4'b1010);
  assign byte_new    = {byte_sr, cfg_data};
  assign byte_last   = (bit_cnt[2:0] == 3'd7);
  assign pay_last    = (bit_cnt == CNT_W'(PAY_BITS - 1));
  assign chk_last    = (bit_cnt == CNT_W'(PAY_BITS + 7));
  assign sum_ok      = (run_xor == rx_sum);
  assign abort       = ~cfg_en & (state != EVAL);
  assign loaded_next = loaded | ((state == EVAL) & sum_ok);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= HUNT;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      HUNT:    if (accept && hdr_hit)  state_next = PAYLOAD;
      PAYLOAD: if (accept && pay_last) state_next = CHECK;
      CHECK:   if (accept && chk_last) state_next = EVAL;
      EVAL:                            state_next = HUNT;
      default:                         state_next = HUNT;
    endcase
    if (abort) state_next = HUNT;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      hist        <= '0;
      bit_cnt     <= '0;
      byte_sr     <= '0;
      run_xor     <= '0;
      rx_sum      <= '0;
      shadow      <= '0;
      loaded      <= 1'b0;
      cfg_bus     <= '0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_ready   <= 1'b0;
      fabric_hold <= 1'b1;
    end else begin
      cfg_done    <= 1'b0;
      cfg_ready   <= (state_next != EVAL);
      fabric_hold <= ~loaded_next | (state_next != HUNT);
      if (abort) begin
        hist    <= '0;
        bit_cnt <= '0;
        byte_sr <= '0;
        run_xor <= '0;
        rx_sum  <= '0;
        shadow  <= '0;
      end else begin
        case (state)
          HUNT: if (accept) begin
            hist <= {hist[1:0], cfg_data};
            if (hdr_hit) begin
              bit_cnt <= '0;
              run_xor <= '0;
              byte_sr <= '0;
            end
          end
          PAYLOAD: if (accept) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            byte_sr <= byte_new[6:0];
            // Bytes enter at the top and drift down, so cell 0 lands in [7:0].
            if (byte_last) begin
              run_xor <= run_xor ^ byte_new;
              shadow  <= {byte_new, shadow[PAY_BITS-1:8]};
            end
          end
          CHECK: if (accept) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            rx_sum  <= {rx_sum[6:0], cfg_data};
          end
          EVAL: begin
            hist    <= '0;
            bit_cnt <= '0;
            if (sum_ok) begin
              cfg_bus  <= shadow;
              cfg_done <= 1'b1;
              cfg_err  <= 1'b0;
              loaded   <= 1'b1;
            end else begin
              cfg_err  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// Testbench for muxpga_cfg_loader: frames are driven serially with random
// valid gaps; each frame's expected commit outcome is queued when sent and
// compared when the loader leaves EVAL.
`timescale 1ns/1ps
module tb_muxpga_cfg_loader;

  localparam int unsigned CELLS = 16;
  localparam int unsigned BW    = CELLS * 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_en = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_data = 1'b0;
  logic          cfg_ready;
  logic [BW-1:0] cfg_bus;
  logic          cfg_done;
  logic          cfg_err;
  logic          fabric_hold;

  muxpga_cfg_loader #(.CELLS(CELLS), .CELL_BITS(8)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_bus(cfg_bus),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .fabric_hold(fabric_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          done;
    logic          err;
    logic          hold;
    logic [BW-1:0] bus;
  } exp_t;

  exp_t          sb_q[$];
  int            total = 0;
  int            passed = 0;
  int            done_seen = 0;
  logic [BW-1:0] m_bus = '0;
  logic          m_loaded = 1'b0;
  logic          m_err = 1'b0;
  logic [7:0]    pay[CELLS];

  always @(negedge clk) if (cfg_done === 1'b1) done_seen++;

  task automatic drive_bit(input logic b, input bit gaps);
    int n;
    n = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (n) begin
      cfg_valid = 1'b0;
      cfg_data  = 1'($urandom);
      @(negedge clk);
    end
    cfg_valid = 1'b1;
    cfg_data  = b;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_header(input bit gaps);
    drive_bit(1'b1, gaps); drive_bit(1'b0, gaps);
    drive_bit(1'b1, gaps); drive_bit(1'b0, gaps);
  endtask

  // Full frame; the expected commit outcome is queued from the bench model.
  task automatic send_frame(input logic [7:0] chk, input bit gaps);
    exp_t          e;
    logic [7:0]    x;
    logic [BW-1:0] img;
    x = 8'h00;
    send_header(gaps);
    for (int k = 0; k < CELLS; k++) begin
      x = x ^ pay[k];
      img[8*k +: 8] = pay[k];
      for (int i = 7; i >= 0; i--) drive_bit(pay[k][i], gaps);
    end
    for (int i = 7; i >= 0; i--) drive_bit(chk[i], gaps);
    if (x == chk) begin
      m_bus = img; m_loaded = 1'b1; m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    e.done = (x == chk);
    e.err  = m_err;
    e.hold = ~m_loaded;
    e.bus  = m_bus;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for the EVAL cycle, optionally offers a bit in it, then
  // compares the committed result against the queued expectation.
  task automatic check_eval(input string tag, input bit offer);
    exp_t e;
    int   n;
    n = 0;
    while (cfg_ready !== 1'b0 && n < 8) begin @(negedge clk); n++; end
    total++;
    if (cfg_ready !== 1'b0) $display("FAIL %s eval_ready: cfg_ready=%b required 0", tag, cfg_ready);
    else passed++;
    if (offer) begin cfg_valid = 1'b1; cfg_data = 1'b1; end
    @(negedge clk);
    cfg_valid = 1'b0;
    total++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s scoreboard: queue size=0 required >0", tag);
    end else begin
      passed++;
      e = sb_q.pop_front();
      total++;
      if (cfg_done !== e.done) $display("FAIL %s done: cfg_done=%b required %b", tag, cfg_done, e.done);
      else passed++;
      total++;
      if (cfg_err !== e.err) $display("FAIL %s err: cfg_err=%b required %b", tag, cfg_err, e.err);
      else passed++;
      total++;
      if (cfg_bus !== e.bus) $display("FAIL %s bus: cfg_bus=%h required %h", tag, cfg_bus, e.bus);
      else passed++;
      total++;
      if (fabric_hold !== e.hold) $display("FAIL %s hold: fabric_hold=%b required %b", tag, fabric_hold, e.hold);
      else passed++;
    end
    @(negedge clk);
    total++;
    if (cfg_done !== 1'b0) $display("FAIL %s done_width: cfg_done=%b required 0", tag, cfg_done);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cfg_bus !== '0) $display("FAIL rst_bus: cfg_bus=%h required 0", cfg_bus); else passed++;
    total++; if (fabric_hold !== 1'b1) $display("FAIL rst_hold: fabric_hold=%b required 1", fabric_hold); else passed++;
    total++; if (cfg_done !== 1'b0) $display("FAIL rst_done: cfg_done=%b required 0", cfg_done); else passed++;
    total++; if (cfg_err !== 1'b0) $display("FAIL rst_err: cfg_err=%b required 0", cfg_err); else passed++;
    total++; if (cfg_ready !== 1'b0) $display("FAIL rst_ready: cfg_ready=%b required 0", cfg_ready); else passed++;
    reset = 1'b0;
    m_bus = '0; m_loaded = 1'b0; m_err = 1'b0;
    @(negedge clk);
    total++; if (cfg_ready !== 1'b1) $display("FAIL rst_release_ready: cfg_ready=%b required 1", cfg_ready); else passed++;
  endtask

  task automatic test_good_frame();
    cfg_en = 1'b1;
    for (int k = 0; k < CELLS; k++) pay[k] = 8'(8'h11 * k);
    send_frame(8'h00, 1'b1);
    check_eval("good", 1'b0);
    total++; if (cfg_bus[31:24] !== 8'h33) $display("FAIL good_cell3: cfg_bus[31:24]=%h required 33", cfg_bus[31:24]); else passed++;
    total++; if (cfg_bus[127:120] !== 8'hFF) $display("FAIL good_cell15: cfg_bus[127:120]=%h required ff", cfg_bus[127:120]); else passed++;
    total++; if (fabric_hold !== 1'b0) $display("FAIL good_hold_after: fabric_hold=%b required 0", fabric_hold); else passed++;
  endtask

  task automatic test_bad_checksum();
    for (int k = 0; k < CELLS; k++) pay[k] = 8'(8'h11 * k);
    send_frame(8'h01, 1'b1);
    check_eval("bad", 1'b0);
    for (int k = 0; k < CELLS; k++) pay[k] = 8'($urandom);
    send_frame(8'h00 ^ pay[0] ^ pay[1] ^ pay[2] ^ pay[3] ^ pay[4] ^ pay[5] ^ pay[6] ^ pay[7]
               ^ pay[8] ^ pay[9] ^ pay[10] ^ pay[11] ^ pay[12] ^ pay[13] ^ pay[14] ^ pay[15], 1'b1);
    check_eval("bad_recover", 1'b0);
  endtask

  task automatic test_abort();
    int done_before;
    done_before = done_seen;
    send_header(1'b1);
    for (int i = 0; i < 50; i++) drive_bit(1'($urandom), 1'b1);
    total++; if (fabric_hold !== 1'b1) $display("FAIL abort_hold_payload: fabric_hold=%b required 1", fabric_hold); else passed++;
    cfg_en = 1'b0;
    cfg_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    total++; if (fabric_hold !== 1'b0) $display("FAIL abort_hold_after: fabric_hold=%b required 0", fabric_hold); else passed++;
    total++; if (cfg_err !== m_err) $display("FAIL abort_err: cfg_err=%b required %b", cfg_err, m_err); else passed++;
    total++; if (cfg_bus !== m_bus) $display("FAIL abort_bus: cfg_bus=%h required %h", cfg_bus, m_bus); else passed++;
    total++; if (done_seen !== done_before) $display("FAIL abort_done: done pulses=%0d required %0d", done_seen, done_before); else passed++;
    cfg_en = 1'b1;
    for (int k = 0; k < CELLS; k++) pay[k] = 8'hA5;
    send_frame(8'h00, 1'b1);
    check_eval("abort_reload", 1'b0);
    total++; if (cfg_bus !== {CELLS{8'hA5}}) $display("FAIL abort_a5: cfg_bus=%h required all a5", cfg_bus); else passed++;
  endtask

  task automatic test_sliding_header();
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < CELLS; k++) begin pay[k] = 8'(7 * k + 3); x = x ^ pay[k]; end
    drive_bit(1'b1, 1'b0);
    send_frame(x, 1'b0);
    check_eval("sliding", 1'b1);
  endtask

  task automatic test_reset_mid();
    send_header(1'b0);
    for (int i = 0; i < 20; i++) drive_bit(1'($urandom), 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_bus = '0; m_loaded = 1'b0; m_err = 1'b0;
    total++; if (cfg_bus !== '0) $display("FAIL midrst_bus: cfg_bus=%h required 0", cfg_bus); else passed++;
    total++; if (fabric_hold !== 1'b1) $display("FAIL midrst_hold: fabric_hold=%b required 1", fabric_hold); else passed++;
    total++; if (cfg_ready !== 1'b0) $display("FAIL midrst_ready: cfg_ready=%b required 0", cfg_ready); else passed++;
    @(negedge clk);
    total++; if (cfg_ready !== 1'b1) $display("FAIL midrst_release_ready: cfg_ready=%b required 1", cfg_ready); else passed++;
    for (int k = 0; k < CELLS; k++) pay[k] = 8'(8'h11 * k);
    send_frame(8'h00, 1'b1);
    check_eval("midrst_hunt", 1'b0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_abort();
    test_sliding_header();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
